// File: rtl/uart_tx_if.sv
// Parallel-word handshake between a data source and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 ready;

    modport master (
        output data,
        output data_valid,
        input  ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload bits LSB-first, STOP_BITS stop bits.
// One word is accepted per valid/ready handshake while idle; serial idles high.
module uart_tx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_if.slave     bus,
    output logic         serial,
    output logic         busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     baud_cnt_q;
    logic [CNT_W-1:0]     baud_cnt_d;
    logic                 bit_done;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 serial_q;
    logic                 ready_q;
    logic                 busy_q;

    assign serial    = serial_q;
    assign busy      = busy_q;
    assign bus.ready = ready_q;

    // Baud counter next value: held at zero while idle, wraps at the end of each bit period.
    always_comb begin
        bit_done   = (baud_cnt_q == CNT_LAST);
        baud_cnt_d = '0;
        if (state_q != IDLE && !bit_done) begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
    end

    // Frame sequencer; serial, ready and busy are all registered here so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            serial_q   <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.data_valid && ready_q) begin
                        shift_q   <= bus.data;
                        bit_idx_q <= '0;
                        serial_q  <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            serial_q  <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            // Next bit is taken from shift_q[1] so serial updates on the same edge as the shift.
                            shift_q   <= shift_q >> 1;
                            serial_q  <= shift_q[1];
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: default-parameter instance plus a 7-bit/2-stop/9600 instance.
module tb_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n1;
    logic serial0, busy0, serial1, busy1;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(7)) bus1 ();

    uart_tx #(.CLK_FREQ(25_000_000), .BAUD_RATE(115_200), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(bus0.slave), .serial(serial0), .busy(busy0));

    uart_tx #(.CLK_FREQ(25_000_000), .BAUD_RATE(9_600), .DATA_BITS(7), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(bus1.slave), .serial(serial1), .busy(busy1));

    typedef struct {
        logic [8:0] data;
        int         gap;     // expected cycles since previous start bit, 0 = not checked
        bit         abort;   // frame is expected to be cut short by reset
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   in_frame0 = 1'b0;
    bit   in_frame1 = 1'b0;
    bit   done1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line_of(input int w);
        return (w == 0) ? serial0 : serial1;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction
    function automatic logic ready_of(input int w);
        return (w == 0) ? bus0.ready : bus1.ready;
    endfunction
    function automatic logic rst_of(input int w);
        return (w == 0) ? rst_n0 : rst_n1;
    endfunction

    task automatic set_in_frame(input int w, input bit v);
        if (w == 0) in_frame0 = v;
        else in_frame1 = v;
    endtask

    // Monitor: on each start bit, pop the expected word and check the line cycle by cycle.
    task automatic monitor(input int w, input int cpb, input int nd, input int ns);
        int prev_start = 0;
        forever begin
            @(negedge clk);
            if (line_of(w) === 1'b0) begin
                exp_t       e;
                int         bad;
                int         len;
                int         start;
                int         b;
                bit         aborted;
                logic       lvl;
                logic [8:0] word;
                start = cyc;
                if ((w == 0 ? q0.size() : q1.size()) == 0) begin
                    chk(w == 0 ? "unexpected_frame0" : "unexpected_frame1", 1, 0);
                    while (line_of(w) !== 1'b1) @(negedge clk);
                    continue;
                end
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                set_in_frame(w, 1'b1);
                bad = 0;
                aborted = 1'b0;
                word = '0;
                len = (1 + nd + ns) * cpb;
                for (int k = 0; k < len; k++) begin
                    if (k != 0) @(negedge clk);
                    b = k / cpb;
                    if (b == 0) lvl = 1'b0;
                    else if (b <= nd) lvl = e.data[b-1];
                    else lvl = 1'b1;
                    if (line_of(w) !== lvl) bad++;
                    if (busy_of(w) !== 1'b1 || ready_of(w) !== 1'b0) bad++;
                    if (b >= 1 && b <= nd && (k % cpb) == cpb / 2) word[b-1] = line_of(w);
                    if (rst_of(w) === 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                chk("abort", int'(aborted), int'(e.abort));
                chk("pattern", bad, 0);
                if (!aborted) begin
                    chk("data", int'(word), int'(e.data));
                    @(negedge clk);
                    chk("end_busy_ready_serial", int'({busy_of(w), ready_of(w), line_of(w)}), 3);
                end
                if (e.gap != 0) chk("gap", start - prev_start, e.gap);
                prev_start = start;
                set_in_frame(w, 1'b0);
            end
        end
    endtask

    initial monitor(0, 217, 8, 1);
    initial monitor(1, 2604, 7, 2);

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send0(input logic [7:0] d, input int gap, input bit abort, input bit hold);
        int   n;
        exp_t e;
        n = 0;
        bus0.data = d;
        bus0.data_valid = 1'b1;
        while (bus0.ready !== 1'b1 && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30000) begin
            chk("ready_wait0", 0, 1);
            bus0.data_valid = 1'b0;
            return;
        end
        e.data = {1'b0, d};
        e.gap = gap;
        e.abort = abort;
        q0.push_back(e);
        @(posedge clk); #1;
        if (!hold) bus0.data_valid = 1'b0;
    endtask

    task automatic send1(input logic [6:0] d);
        int   n;
        exp_t e;
        n = 0;
        bus1.data = d;
        bus1.data_valid = 1'b1;
        while (bus1.ready !== 1'b1 && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30000) begin
            chk("ready_wait1", 0, 1);
            bus1.data_valid = 1'b0;
            return;
        end
        e.data = {2'b00, d};
        e.gap = 0;
        e.abort = 1'b0;
        q1.push_back(e);
        @(posedge clk); #1;
        bus1.data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int w);
        int n;
        n = 0;
        while (((w == 0) ? (q0.size() != 0 || in_frame0) : (q1.size() != 0 || in_frame1)) && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40000) chk("idle_wait", 0, 1);
    endtask

    task automatic count_low0(input string name, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (serial0 !== 1'b1) lows++;
        end
        chk(name, lows, 0);
        @(posedge clk); #1;
    endtask

    // Parameter-sweep instance: 7 data bits, 2 stop bits, 2604 clocks per bit.
    initial begin
        rst_n1 = 1'b0;
        bus1.data = '0;
        bus1.data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n1 = 1'b1;
        send1(7'h55);
        wait_idle(1);
        done1 = 1'b1;
    end

    // Default instance: directed scenarios.
    initial begin
        int n;
        rst_n0 = 1'b0;
        bus0.data = '0;
        bus0.data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n0 = 1'b1;
        @(negedge clk);
        chk("reset_serial", int'(serial0), 1);
        chk("reset_ready", int'(bus0.ready), 1);
        chk("reset_busy", int'(busy0), 0);
        @(posedge clk); #1;
        count_low0("idle_high", 1000);

        send0(8'hA5, 0, 1'b0, 1'b0);
        wait_idle(0);

        send0(8'h00, 0, 1'b0, 1'b1);
        send0(8'hFF, 2171, 1'b0, 1'b0);
        wait_idle(0);

        send0(8'h5A, 0, 1'b0, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        chk("busy_at_pulse", int'(busy0), 1);
        bus0.data = 8'h3C;
        bus0.data_valid = 1'b1;
        @(posedge clk); #1;
        bus0.data_valid = 1'b0;
        wait_idle(0);
        count_low0("ignored_not_sent", 3000);

        send0(8'h0F, 0, 1'b1, 1'b0);
        repeat (950) @(posedge clk);
        #1 rst_n0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_serial", int'(serial0), 1);
        chk("midreset_busy", int'(busy0), 0);
        repeat (3) @(posedge clk);
        #1 rst_n0 = 1'b1;
        @(negedge clk);
        chk("release_ready", int'(bus0.ready), 1);
        @(posedge clk); #1;
        send0(8'h81, 0, 1'b0, 1'b0);
        wait_idle(0);

        n = 0;
        while (!done1 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        chk("sweep_done", int'(done1), 1);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion before it", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1-style framing with configurable data width and stop bits; drives ftdi_rxd on the ULX3S toward the host.
- Counterpart of the team's UART_RX; uses the same CLK_FREQ / BAUD_RATE / DATA_BITS parameterisation.
- Accepts one parallel word per valid/ready handshake, serialises it LSB-first, and reports busy while a frame is on the line.

Parameters:
- CLK_FREQ, 25_000_000, input clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bit/s.
- DATA_BITS, 8, payload bits per frame, legal range 5..9.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- data  input  DATA_BITS  word to transmit; sampled on the handshake cycle.
- data_valid  input  1  word on data is valid.
- ready  output  1  block can accept a word this cycle.
- serial  output  1  UART line; idles high.
- busy  output  1  a frame is in progress, from start bit through the last stop bit.

Behaviour:
- Reset: rst_n is sampled on posedge clk. While low, the FSM goes to IDLE, serial=1, ready=1, busy=0, and the baud and bit counters clear. Reset asserted mid-frame aborts the frame immediately, and serial returns high on the next edge.
- Bit period: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division and truncated (217 at the defaults). The baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit.
- Handshake: a transfer occurs on a cycle where data_valid && ready. The data word is latched into the shift register on that edge. The source may change data afterwards.
- Handshake: ready=1 only in IDLE. data_valid while ready=0 is ignored and not queued; the source must hold data_valid until it sees ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial=1, ready=1, busy=0. On handshake, go to START; from the next cycle, serial=0, busy=1, ready=0.
  - START: hold serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial = shift register bit 0, held for CLKS_PER_BIT cycles, then shift right and increment the index. After index DATA_BITS-1 completes, go to STOP.
  - STOP: serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE. ready and busy change on the cycle of the return to IDLE.
- Latency: the serial falling edge appears 1 clock after the handshake edge. Frame length is (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT clocks. Back-to-back words have no idle gap beyond the 1 handshake cycle in IDLE.
- serial is driven directly from a flop, so it is glitch-free.
- Simultaneous events: reset has priority over a handshake in the same cycle. The word is dropped and the block stays in IDLE.
- No parity and no error output.

Test Plan:
- Reset, defaults: hold rst_n=0 for 5 cycles, then release -> serial=1, ready=1, busy=0, and the line stays high for 1000 cycles with data_valid=0.
- Single byte: send 0xA5 with defaults -> serial low for exactly 217 clocks, then bits 1,0,1,0,0,1,0,1 at 217 clocks each, then high for 217; busy high for 2170 clocks; ready returns the cycle after.
- Back-to-back: hold data_valid=1 and present 0x00 then 0xFF -> second start bit begins 2171 clocks after the first. A loopback through UART_RX (same params) yields data_valid with 0x00 then 0xFF and no error.
- Ignored input: pulse data_valid with 0x3C mid-frame while busy=1 -> not transmitted, and the current frame is unchanged.
- Reset mid-frame: assert rst_n=0 during the DATA bit 3 of 0x0F -> serial=1 on the next edge and ready=1 after release. A following 0x81 is transmitted cleanly.
- Parameter sweep: DATA_BITS=7, STOP_BITS=2, BAUD_RATE=9600, send 0x55 -> CLKS_PER_BIT=2604, frame = 10*2604 clocks, and the final stop level lasts 5208 clocks.
